// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter and neighbouring bus logic.
//   word_t      : one machine word
//   ramstate_t  : status reported by the RAM each cycle
//   arb_state_t : arbiter FSM states
//   arb_kind_t  : kind of access latched for the current grant
//   idx_w()     : index width for N requesters, never below 1
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    ARB_I  = 2'd0,
    ARB_DR = 2'd1,
    ARB_DW = 2'd2
  } arb_kind_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// at or after i_ptr, wrapping modulo N.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index with highest priority this cycle
//   o_idx   : winning index (0 when nothing is requested)
//   o_valid : at least one request is asserted
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int w_slot;

  // Scan from the farthest slot back towards i_ptr so the closest
  // requester is the last one written and therefore wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_slot  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_slot = (int'(i_ptr) + k) % N;
      if (i_req[IW'(w_slot)]) begin
        o_idx   = IW'(w_slot);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared-RAM arbiter for CPUS cores. One request is granted at a time:
// round-robin across cores, data before instruction inside a core.
// The grant is held until the RAM reports ACCESS; the matching wait line
// drops and the load data is forwarded in that same cycle.
//
// Ports
//   CLK, nRST            : clock, synchronous active-low reset
//   iREN/iaddr           : per-core instruction fetch request / address
//   dREN/dWEN/daddr/dstore: per-core data read, write, address, store data
//   iwait/dwait          : per-core "not complete this cycle"
//   iload/dload          : per-core returned data, zero unless completing
//   ramREN/ramWEN        : RAM strobes, driven only from latched fields
//   ramaddr/ramstore     : RAM address / write data
//   ramload/ramstate     : RAM read data / RAM status
//
// state | meaning
// IDLE  | no grant; pick a winner and latch its request
// GRANT | latched request on the RAM port until ramstate == ACCESS
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  input  logic [WORD_W-1:0]            ramload,
  input  ramstate_t                    ramstate
);

  localparam int CW = idx_w(CPUS);

  arb_state_t        r_state,  w_state_nxt;
  logic [CW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0]     r_core,   w_core_nxt;
  arb_kind_t         r_kind,   w_kind_nxt;
  logic [WORD_W-1:0] r_addr,   w_addr_nxt;
  logic [WORD_W-1:0] r_store,  w_store_nxt;

  logic [CPUS-1:0]   w_req;
  logic [CW-1:0]     w_pick_idx;
  logic              w_pick_valid;
  logic              w_done;
  logic              w_hit;

  assign w_req = iREN | dREN | dWEN;

  rr_pick #(
    .N  (CPUS),
    .IW (CW)
  ) u_rr_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_core   <= '0;
      r_kind   <= ARB_I;
      r_addr   <= '0;
      r_store  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_core   <= w_core_nxt;
      r_kind   <= w_kind_nxt;
      r_addr   <= w_addr_nxt;
      r_store  <= w_store_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_core_nxt   = r_core;
    w_kind_nxt   = r_kind;
    w_addr_nxt   = r_addr;
    w_store_nxt  = r_store;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    w_done       = 1'b0;
    w_hit        = 1'b0;
    iwait        = iREN;
    dwait        = dREN | dWEN;
    iload        = '0;
    dload        = '0;

    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_core_nxt  = w_pick_idx;
          w_store_nxt = dstore[w_pick_idx];
          // A simultaneous read and write is treated as a write.
          if (dWEN[w_pick_idx]) begin
            w_kind_nxt = ARB_DW;
            w_addr_nxt = daddr[w_pick_idx];
          end else if (dREN[w_pick_idx]) begin
            w_kind_nxt = ARB_DR;
            w_addr_nxt = daddr[w_pick_idx];
          end else begin
            w_kind_nxt = ARB_I;
            w_addr_nxt = iaddr[w_pick_idx];
          end
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Strobes come from latched state only, so ramstate never
        // reaches them combinationally. ERROR simply keeps the grant.
        ramREN   = (r_kind != ARB_DW);
        ramWEN   = (r_kind == ARB_DW);
        ramaddr  = r_addr;
        ramstore = r_store;
        if (ramstate == ACCESS) begin
          // A reset arriving in the completion cycle abandons the grant.
          w_done       = nRST;
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = (r_core == CW'(CPUS - 1)) ? '0 : r_core + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    for (int c = 0; c < CPUS; c++) begin
      w_hit = w_done && (r_core == CW'(c));
      if (w_hit && (r_kind == ARB_I)) begin
        iwait[c] = 1'b0;
        iload[c] = ramload;
      end
      if (w_hit && (r_kind != ARB_I)) begin
        dwait[c] = 1'b0;
        dload[c] = ramload;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int W    = 32;

  logic                   CLK;
  logic                   nRST;
  logic [CPUS-1:0]        iREN, dREN, dWEN;
  logic [CPUS-1:0][W-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]        iwait, dwait;
  logic [CPUS-1:0][W-1:0] iload, dload;
  logic                   ramREN, ramWEN;
  logic [W-1:0]           ramaddr, ramstore, ramload;
  ramstate_t              ramstate;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // The model only remembers the outstanding grant (who, what kind,
  // where, data) and whose turn is next; outputs are derived from it.
  bit          m_live    = 0;
  bit          m_granted = 0;
  int          m_core    = 0;
  int          m_kind    = 0;   // 0 fetch, 1 data read, 2 data write
  logic [W-1:0] m_addr   = '0;
  logic [W-1:0] m_store  = '0;
  int          m_next    = 0;

  always @(posedge CLK) begin
    if (!nRST) begin
      m_live    <= 1;
      m_granted <= 0;
      m_next    <= 0;
      m_core    <= 0;
      m_kind    <= 0;
      m_addr    <= '0;
      m_store   <= '0;
    end else if (!m_granted) begin
      bit found;
      int c;
      found = 0;
      for (int k = 0; k < CPUS; k++) begin
        c = (m_next + k) % CPUS;
        if (!found && (iREN[c] || dREN[c] || dWEN[c])) begin
          found = 1;
          m_granted <= 1;
          m_core    <= c;
          m_store   <= dstore[c];
          if (dWEN[c])      begin m_kind <= 2; m_addr <= daddr[c]; end
          else if (dREN[c]) begin m_kind <= 1; m_addr <= daddr[c]; end
          else              begin m_kind <= 0; m_addr <= iaddr[c]; end
        end
      end
    end else if (ramstate == ACCESS) begin
      m_granted <= 0;
      m_next    <= (m_core + 1) % CPUS;
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      logic [CPUS-1:0]        e_iwait, e_dwait;
      logic [CPUS-1:0][W-1:0] e_iload, e_dload;
      bit done;
      done    = m_granted && nRST && (ramstate == ACCESS);
      e_iwait = iREN;
      e_dwait = dREN | dWEN;
      e_iload = '0;
      e_dload = '0;
      if (done && m_kind == 0) begin e_iwait[m_core] = 1'b0; e_iload[m_core] = ramload; end
      if (done && m_kind != 0) begin e_dwait[m_core] = 1'b0; e_dload[m_core] = ramload; end
      check("m_iwait", iwait, e_iwait);
      check("m_dwait", dwait, e_dwait);
      check("m_iload", iload, e_iload);
      check("m_dload", dload, e_dload);
      check("m_ramREN", ramREN, m_granted && m_kind != 2);
      check("m_ramWEN", ramWEN, m_granted && m_kind == 2);
      check("m_ramaddr", ramaddr, m_granted ? m_addr : '0);
      check("m_ramstore", ramstore, m_granted ? m_store : '0);
    end
  end

  // ---------------- stimulus and hand-computed expectations ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    ramstate = FREE;
  endtask

  initial begin
    int order[$];
    int exp_order[4] = '{0, 1, 0, 1};
    ramstate_t seq[4] = '{BUSY, ERROR, ERROR, ACCESS};
    int ncomp;

    nRST = 0; iREN = 2'b11; dREN = '0; dWEN = '0;
    iaddr[0] = 32'h10; iaddr[1] = 32'h14;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset held with both fetches pending
    repeat (3) tick();
    @(negedge CLK);
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramWEN", ramWEN, 1'b0);
    check("rst_iwait", iwait, 2'b11);
    check("rst_ramaddr", ramaddr, 32'h0);
    tick(); nRST = 1; ramstate = ACCESS;
    @(negedge CLK);
    check("rel_no_strobe", ramREN, 1'b0);
    tick();
    @(negedge CLK);
    check("rel_strobe", ramREN, 1'b1);
    check("rel_addr", ramaddr, 32'h10);
    check("rel_iwait", iwait, 2'b10);
    tick(); idle_inputs();
    tick();

    // Single fetch, core0
    iREN = 2'b01; iaddr[0] = 32'h100; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    check("f_wait_c1", iwait[0], 1'b1);
    tick();
    @(negedge CLK);
    check("f_wait_c2", iwait[0], 1'b0);
    check("f_iload", iload[0], 32'hDEADBEEF);
    check("f_ramaddr", ramaddr, 32'h100);
    check("f_ramREN", ramREN, 1'b1);
    tick(); idle_inputs();
    tick();

    // Core1 store beats core1 fetch
    iREN = 2'b10; dWEN = 2'b10; iaddr[1] = 32'h300;
    daddr[1] = 32'h200; dstore[1] = 32'h55; ramstate = ACCESS; ramload = 32'h1234;
    tick();
    @(negedge CLK);
    check("p_ramWEN", ramWEN, 1'b1);
    check("p_ramREN", ramREN, 1'b0);
    check("p_addr", ramaddr, 32'h200);
    check("p_store", ramstore, 32'h55);
    check("p_dwait", dwait, 2'b00);
    check("p_iwait", iwait, 2'b10);
    tick(); dWEN = '0;
    @(negedge CLK);
    check("p_gap", ramREN, 1'b0);
    tick();
    @(negedge CLK);
    check("p_fetch_addr", ramaddr, 32'h300);
    check("p_fetch_iload", iload[1], 32'h1234);
    tick(); idle_inputs();
    tick();

    // Round-robin with both cores holding data reads
    dREN = 2'b11; daddr[0] = 32'hA0; daddr[1] = 32'hB0; ramstate = ACCESS;
    for (int cyc = 0; cyc < 12 && order.size() < 4; cyc++) begin
      @(negedge CLK);
      for (int c = 0; c < CPUS; c++)
        if (!dwait[c]) order.push_back(c);
      tick();
    end
    check("rr_count", order.size(), 4);
    for (int k = 0; k < 4; k++)
      check("rr_order", (k < order.size()) ? order[k] : -1, exp_order[k]);
    idle_inputs();
    tick();

    // BUSY/ERROR/ERROR/ACCESS on one data read
    dREN = 2'b01; daddr[0] = 32'h400; ramstate = BUSY; ramload = 32'h77;
    tick();
    ncomp = 0;
    for (int k = 0; k < 4; k++) begin
      ramstate = seq[k];
      @(negedge CLK);
      check("e_ramREN", ramREN, 1'b1);
      check("e_addr", ramaddr, 32'h400);
      check("e_dwait", dwait[0], (seq[k] == ACCESS) ? 1'b0 : 1'b1);
      if (!dwait[0]) ncomp++;
      tick();
    end
    idle_inputs();
    @(negedge CLK);
    check("e_completions", ncomp, 1);
    check("e_after", ramREN, 1'b0);
    tick();

    // Reset while core1 is granted and RAM is busy
    dREN = 2'b10; daddr[1] = 32'h500; daddr[0] = 32'h600; ramstate = BUSY;
    tick();
    @(negedge CLK);
    check("r_granted", ramaddr, 32'h500);
    tick(); nRST = 0; dREN = 2'b11;
    tick(); nRST = 1; ramstate = ACCESS;
    @(negedge CLK);
    check("r_ramREN", ramREN, 1'b0);
    tick();
    @(negedge CLK);
    check("r_fresh_addr", ramaddr, 32'h600);
    check("r_fresh_dwait", dwait, 2'b10);
    tick(); idle_inputs();
    tick();

    // Random traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      nRST     = ($urandom_range(0, 199) != 0);
      iREN     = CPUS'($urandom);
      dREN     = CPUS'($urandom);
      dWEN     = CPUS'($urandom_range(0, 3) == 0 ? $urandom : 0);
      for (int c = 0; c < CPUS; c++) begin
        iaddr[c]  = $urandom;
        daddr[c]  = $urandom;
        dstore[c] = $urandom;
      end
      ramload  = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      tick();
    end

    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
